// File: rtl/filter_pkg.sv
// Shared definitions for the linear interpolating upsampler.
// Contents: FSM state encoding, default widths and width helpers for the
// accumulator and segment slope registers.
package filter_pkg;

    localparam int unsigned DATA_WIDTH_DEF   = 16;
    localparam int unsigned INTERP_WIDTH_DEF = 4;
    localparam int unsigned INTERVAL_W       = 8;

    // Accumulator holds prev*L plus up to L-1 slope steps, so one guard bit
    // on top of the scaled sample is enough.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned iw);
        return dw + iw + 1;
    endfunction

    // Difference of two signed DATA_WIDTH samples.
    function automatic int unsigned delta_width(input int unsigned dw);
        return dw + 1;
    endfunction

    localparam int unsigned ACC_W   = acc_width(DATA_WIDTH_DEF, INTERP_WIDTH_DEF);
    localparam int unsigned DELTA_W = delta_width(DATA_WIDTH_DEF);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        STALL = 2'd3
    } state_t;

endpackage

// File: rtl/linear_interp_upsampler_if.sv
// Stream bundle for the upsampler: input handshake, output pacing control,
// interpolated output strobe and underrun flag.
//   master: drives i_data/i_valid/i_out_interval, observes everything else
//   slave : the upsampler itself
interface linear_interp_upsampler_if #(
    parameter int unsigned DATA_WIDTH = filter_pkg::DATA_WIDTH_DEF
) ();

    logic signed [DATA_WIDTH-1:0]           i_data;
    logic                                   i_valid;
    logic                                   i_ready;
    logic [filter_pkg::INTERVAL_W-1:0]      i_out_interval;
    logic signed [DATA_WIDTH-1:0]           o_data;
    logic                                   o_valid;
    logic                                   o_underrun;

    modport master (
        output i_data, i_valid, i_out_interval,
        input  i_ready, o_data, o_valid, o_underrun
    );

    modport slave (
        input  i_data, i_valid, i_out_interval,
        output i_ready, o_data, o_valid, o_underrun
    );

endinterface

// File: rtl/interp_pacer.sv
// Output point pacer: counts 0..interval-1 while enabled and flags the last
// count. load latches a new interval (0 behaves as 1) and restarts the count.
// Ports: clk, rst (async active-low), load, en, interval, tick_c (comb).
module interp_pacer
    import filter_pkg::*;
#(
    parameter int unsigned W = INTERVAL_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] interval,
    output logic         tick_c
);

    logic [W-1:0] cnt;
    logic [W-1:0] last;

    always_comb tick_c = en && (cnt == last);

    // Interval is captured as its terminal count so the compare stays simple.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            last <= '0;
        end else if (load) begin
            cnt  <= '0;
            last <= (interval == '0) ? '0 : interval - W'(1);
        end else if (en) begin
            cnt <= tick_c ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/linear_interp_upsampler.sv
// Linear interpolating upsampler: turns a low-rate sample stream into
// 2**INTERP_WIDTH evenly spaced points per pair of consecutive samples,
// emitted one every i_out_interval clocks.
// Ports: clk, rst (async active-low), bus (slave modport: i_data, i_valid,
//        i_ready, i_out_interval, o_data, o_valid, o_underrun).
module linear_interp_upsampler
    import filter_pkg::*;
#(
    parameter int unsigned INTERP_WIDTH = INTERP_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    linear_interp_upsampler_if.slave  bus
);

    localparam int unsigned ACC_WIDTH   = acc_width(DATA_WIDTH, INTERP_WIDTH);
    localparam int unsigned DELTA_WIDTH = delta_width(DATA_WIDTH);
    localparam logic [INTERP_WIDTH-1:0] K_LAST = '1;

    state_t                         state;
    logic signed [DATA_WIDTH-1:0]   prev;
    logic signed [DATA_WIDTH-1:0]   cur;
    logic signed [DATA_WIDTH-1:0]   nxt;
    logic                           nxt_full;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [DELTA_WIDTH-1:0]  delta;
    logic [INTERP_WIDTH-1:0]        k;

    logic signed [DATA_WIDTH-1:0]   o_data_q;
    logic                           o_valid_q;
    logic                           o_underrun_q;
    logic                           i_ready_q;

    logic                           xfer;
    logic                           tick;
    logic                           seg_end;
    logic                           seg_load;
    logic signed [DATA_WIDTH-1:0]   seg_prev;
    logic signed [DATA_WIDTH-1:0]   seg_cur;
    logic                           nxt_full_d;
    logic                           nxt_wr;

    assign bus.o_data     = o_data_q;
    assign bus.o_valid    = o_valid_q;
    assign bus.o_underrun = o_underrun_q;
    assign bus.i_ready    = i_ready_q;

    assign xfer    = bus.i_valid & i_ready_q;
    assign seg_end = (state == RUN) && tick && (k == K_LAST);

    interp_pacer #(.W(INTERVAL_W)) u_pacer (
        .clk      (clk),
        .rst      (rst),
        .load     (seg_load),
        .en       (state == RUN),
        .interval (bus.i_out_interval),
        .tick_c   (tick)
    );

    // Segment load decision and holding-slot bookkeeping.
    // At a segment end the held sample wins; a same-cycle transfer refills nxt.
    always_comb begin
        seg_load   = 1'b0;
        seg_prev   = cur;
        seg_cur    = bus.i_data;
        nxt_full_d = nxt_full;
        nxt_wr     = 1'b0;
        case (state)
            PRIME: begin
                if (xfer) begin
                    seg_load = 1'b1;
                    seg_prev = prev;
                end
            end
            RUN: begin
                if (seg_end && (nxt_full || xfer)) begin
                    seg_load = 1'b1;
                    if (nxt_full) seg_cur = nxt;
                end
                if (seg_load && nxt_full) begin
                    nxt_full_d = xfer;
                    nxt_wr     = xfer;
                end else if (!seg_load && xfer) begin
                    nxt_full_d = 1'b1;
                    nxt_wr     = 1'b1;
                end
            end
            STALL: begin
                if (xfer) seg_load = 1'b1;
            end
            default: ;
        endcase
    end

    // FSM, endpoint registers, accumulator and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= EMPTY;
            prev         <= '0;
            cur          <= '0;
            nxt          <= '0;
            nxt_full     <= 1'b0;
            acc          <= '0;
            delta        <= '0;
            k            <= '0;
            o_data_q     <= '0;
            o_valid_q    <= 1'b0;
            o_underrun_q <= 1'b0;
            i_ready_q    <= 1'b1;
        end else begin
            o_valid_q    <= 1'b0;
            o_underrun_q <= 1'b0;
            case (state)
                EMPTY: begin
                    if (xfer) begin
                        prev  <= bus.i_data;
                        state <= PRIME;
                    end
                end
                PRIME: begin
                    if (xfer) state <= RUN;
                end
                RUN: begin
                    if (tick) begin
                        // Arithmetic shift floors toward minus infinity.
                        o_data_q  <= DATA_WIDTH'(acc >>> INTERP_WIDTH);
                        o_valid_q <= 1'b1;
                        acc       <= acc + ACC_WIDTH'(delta);
                        k         <= k + INTERP_WIDTH'(1);
                    end
                    if (seg_end && !seg_load) begin
                        o_underrun_q <= 1'b1;
                        state        <= STALL;
                    end
                end
                STALL: begin
                    if (xfer) state <= RUN;
                end
                default: state <= EMPTY;
            endcase

            if (nxt_wr) nxt <= bus.i_data;
            nxt_full  <= nxt_full_d;
            i_ready_q <= ~nxt_full_d;

            // New segment overrides the running accumulator step above.
            if (seg_load) begin
                prev  <= seg_prev;
                cur   <= seg_cur;
                acc   <= ACC_WIDTH'(seg_prev) <<< INTERP_WIDTH;
                delta <= DELTA_WIDTH'(seg_cur) - DELTA_WIDTH'(seg_prev);
                k     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_linear_interp_upsampler.sv
// Self-checking bench for linear_interp_upsampler: accepted samples feed a
// segment-level reference model whose points are queued; a monitor pops and
// compares on every o_valid.
module tb_linear_interp_upsampler;

    localparam int unsigned DW = 16;
    localparam int unsigned IW = 4;
    localparam int          L  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    linear_interp_upsampler_if #(.DATA_WIDTH(DW)) ifc ();

    linear_interp_upsampler #(.INTERP_WIDTH(IW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int checks   = 0;
    int failures = 0;

    int exp_q[$];
    int last_sample;
    bit have_prev;
    int cyc = 0;

    int n_valid, n_under, n_acc;
    int first_valid_edge, seg1_edge, last_valid_edge;
    int exp_spacing;
    bit chk_spacing;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Point k of the segment a->b: floor((a*L + k*(b-a)) / L).
    function automatic int interp_point(input int a, input int b, input int kk);
        int num;
        int q;
        num = a * L + kk * (b - a);
        q   = num / L;
        if ((num % L) != 0 && num < 0) q = q - 1;
        return q;
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: inputs and outputs are stable at the falling edge.
    always @(negedge clk) begin
        int v;
        if (rst) begin
            if (ifc.i_valid && ifc.i_ready) begin
                v = int'(ifc.i_data);
                n_acc++;
                if (have_prev) begin
                    for (int kk = 0; kk < L; kk++) exp_q.push_back(interp_point(last_sample, v, kk));
                    if (n_acc == 2) seg1_edge = cyc + 1;
                end
                last_sample = v;
                have_prev   = 1'b1;
            end
            if (ifc.o_valid) begin
                n_valid++;
                if (n_valid == 1) first_valid_edge = cyc;
                else if (chk_spacing) check("o_valid_spacing", cyc - last_valid_edge, exp_spacing);
                last_valid_edge = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_o_valid: got o_data=%0d expected no output", int'(ifc.o_data));
                end else begin
                    check("o_data", int'(ifc.o_data), exp_q.pop_front());
                end
            end
            if (ifc.o_underrun) n_under++;
        end
    end

    task automatic start_phase(input int interval);
        ifc.i_out_interval = 8'(interval);
        n_valid = 0; n_under = 0; n_acc = 0;
        first_valid_edge = -1; seg1_edge = -1; last_valid_edge = 0;
        exp_spacing = (interval == 0) ? 1 : interval;
        chk_spacing = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        exp_q.delete();
        have_prev = 1'b0;
        ifc.i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_o_valid", int'(ifc.o_valid), 0);
        check("rst_o_data", int'(ifc.o_data), 0);
        check("rst_o_underrun", int'(ifc.o_underrun), 0);
        check("rst_i_ready", int'(ifc.i_ready), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one sample and hold it until a transfer edge (bounded).
    task automatic send(input int v);
        int  n;
        bit  ok;
        ifc.i_data  = DW'(v);
        ifc.i_valid = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 1000) begin
            @(negedge clk);
            ok = ifc.i_ready;
            n++;
            @(posedge clk);
            #1;
        end
        ifc.i_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got no accept for sample %0d expected accept within 1000 clocks", v);
        end
    endtask

    task automatic end_phase(input string name, input int exp_valid, input int exp_under, input int exp_lat);
        check({name, "_points"}, n_valid, exp_valid);
        check({name, "_underruns"}, n_under, exp_under);
        check({name, "_queue_left"}, exp_q.size(), 0);
        if (exp_lat > 0) check({name, "_latency"}, first_valid_edge - seg1_edge, exp_lat);
    endtask

    function automatic int rand_sample();
        logic signed [DW-1:0] r;
        r = DW'($urandom);
        return int'(r);
    endfunction

    initial begin
        int iv;
        int s0, s1;
        ifc.i_data = '0;
        ifc.i_valid = 1'b0;
        ifc.i_out_interval = 8'd1;

        // Ramp 0,160,320 back-to-back at one point per clock.
        reset_dut();
        start_phase(1);
        chk_spacing = 1'b1;
        send(0); send(160); send(320);
        wait_cycles(80);
        end_phase("ramp", 32, 1, 1);

        // Negative start, step 2.
        reset_dut();
        start_phase(1);
        send(-16); send(16);
        wait_cycles(40);
        end_phase("neg_step", 16, 1, 1);

        // Floor rounding on a tiny negative slope.
        reset_dut();
        start_phase(1);
        send(0); send(-1);
        wait_cycles(40);
        end_phase("floor", 16, 1, 1);

        // Interval 4 with samples offered every clock: holding slot fills.
        reset_dut();
        start_phase(4);
        chk_spacing = 1'b1;
        send(1000); send(-2000); send(3000);
        check("i_ready_after_3rd", int'(ifc.i_ready), 0);
        send(-500);
        wait_cycles(260);
        end_phase("skid", 48, 1, 4);

        // Underrun then resume from the old endpoint.
        reset_dut();
        iv = int'($urandom_range(1, 3));
        start_phase(iv);
        s0 = rand_sample();
        s1 = rand_sample();
        send(s0); send(s1);
        wait_cycles(200);
        end_phase("underrun", 16, 1, iv);
        send(32);
        wait_cycles(16 * iv + 20);
        end_phase("resume", 32, 2, 0);

        // Asynchronous reset while points are streaming.
        reset_dut();
        start_phase(1);
        send(100); send(200);
        begin
            int n;
            n = 0;
            while (!ifc.o_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("midrun_saw_o_valid", int'(ifc.o_valid), 1);
        end
        #1 rst = 1'b0;
        #1;
        check("async_o_valid", int'(ifc.o_valid), 0);
        check("async_o_data", int'(ifc.o_data), 0);
        check("async_i_ready", int'(ifc.i_ready), 1);
        exp_q.delete();
        have_prev = 1'b0;
        wait_cycles(2);
        rst = 1'b1;
        start_phase(1);
        send(-300);
        wait_cycles(50);
        end_phase("reprime_one", 0, 0, 0);
        send(700);
        wait_cycles(40);
        end_phase("reprime_two", 16, 1, 1);

        // Randomized stream with random gaps; interval 0 behaves as 1.
        for (int rep = 0; rep < 3; rep++) begin
            reset_dut();
            iv = (rep == 0) ? 0 : int'($urandom_range(1, 5));
            start_phase(iv);
            for (int i = 0; i < 8; i++) begin
                wait_cycles(int'($urandom_range(0, 90)));
                send(rand_sample());
            end
            wait_cycles(16 * 5 + 200);
            end_phase("random", 7 * L, n_under, (iv == 0) ? 1 : iv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no finish expected end of run before 800000");
        $fatal(1);
    end

endmodule
